// File: rtl/stream_src_pkg.sv
// rtl/stream_src_pkg.sv - shared state type and width helpers for the stream_src packet source
package stream_src_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  // Widths for the default 16-element build; parametrised modules use the helpers below.
  localparam int DEF_MAX_LENGTH = 16;
  localparam int LEN_W          = $clog2(DEF_MAX_LENGTH + 1);
  localparam int IDX_W          = $clog2(DEF_MAX_LENGTH);
  localparam int GAP_W          = 8;

  // Bits needed to hold an element count 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Bits needed to address an element 0..max_len-1 (at least one bit).
  function automatic int idx_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/stream_src_idx.sv
// rtl/stream_src_idx.sv - beat counter and element index generator for stream_src
module stream_src_idx
  import stream_src_pkg::*;
#(
  parameter int MAX_LENGTH = 16,
  parameter bit MSB_FIRST  = 1'b1,
  localparam int LEN_BITS  = len_width(MAX_LENGTH),
  localparam int IDX_BITS  = idx_width(MAX_LENGTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [LEN_BITS-1:0] len,
  input  logic                advance,
  output logic [IDX_BITS-1:0] idx,
  output logic                first,
  output logic                last
);

  logic [IDX_BITS-1:0] beat_q, beat_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] len_m1;
  logic [IDX_BITS-1:0] last_beat;

  // Next beat position: restart on a new frame, step on each accepted non-final beat.
  always_comb begin
    beat_d = beat_q;
    len_d  = len_q;
    if (start) begin
      beat_d = '0;
      len_d  = len;
    end else if (advance) begin
      beat_d = beat_q + IDX_BITS'(1);
    end
  end

  // Outputs describe the beat about to be loaded into the output register.
  assign len_m1    = len_d - LEN_BITS'(1);
  assign last_beat = len_m1[IDX_BITS-1:0];
  assign idx       = MSB_FIRST ? (last_beat - beat_d) : beat_d;
  assign first     = (beat_d == '0);
  assign last      = (beat_d == last_beat);

  // Track the beat currently held in the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
      len_q  <= '0;
    end else begin
      beat_q <= beat_d;
      len_q  <= len_d;
    end
  end

endmodule

// File: rtl/stream_src.sv
// rtl/stream_src.sv - parallel frame to streamed packet source; STREAM_SRC_PKT_CNT_EN adds packet/error counters
module stream_src
  import stream_src_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LENGTH = 16,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             load,
  input  logic [$clog2(MAX_LENGTH+1)-1:0]  len,
  input  logic [MAX_LENGTH*DATA_WIDTH-1:0] data_in,
  output logic                             load_ready,
  output logic                             len_err,
  output logic                             valid,
  input  logic                             ready,
  output logic                             sop,
  output logic                             eop,
  output logic [DATA_WIDTH-1:0]            data_out
`ifdef STREAM_SRC_PKT_CNT_EN
  ,
  output logic [15:0]                      pkt_cnt,
  output logic [7:0]                       err_cnt
`endif
);

  localparam int LEN_BITS = len_width(MAX_LENGTH);
  localparam int IDX_BITS = idx_width(MAX_LENGTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                          state_q, state_d;
  logic [GAP_W-1:0]                gap_q, gap_d;
  logic [MAX_LENGTH*DATA_WIDTH-1:0] frame_q, frame_sel;
  logic                            eop_done, take, len_ok, start, advance;
  logic                            valid_d, sop_d, eop_d;
  logic [DATA_WIDTH-1:0]           data_d;
  logic [IDX_BITS-1:0]             idx;
  logic                            first, last;

  // Handshake: accept frames in IDLE, or on the final accepted beat when no gap is required.
  assign eop_done   = valid && ready && eop;
  assign load_ready = reset_n && ((state_q == IDLE) ||
                                  ((GAP_CYCLES == 0) && (state_q == SEND) && eop_done));
  assign take       = load && load_ready;
  assign len_ok     = (len != '0) && (len <= LEN_BITS'(MAX_LENGTH));
  assign start      = take && len_ok;
  assign advance    = valid && ready && !eop;
  assign frame_sel  = start ? data_in : frame_q;

  stream_src_idx #(
    .MAX_LENGTH (MAX_LENGTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_idx (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .len     (len),
    .advance (advance),
    .idx     (idx),
    .first   (first),
    .last    (last)
  );

  // Next-state logic: IDLE -> SEND on a legal frame, SEND -> GAP/IDLE after the final beat.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SEND;
      end
      SEND: begin
        if (eop_done) begin
          if (start) begin
            state_d = SEND;
          end else if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Next output beat: load a new element on start/advance, go idle after the final beat, else hold.
  always_comb begin
    valid_d = valid;
    sop_d   = sop;
    eop_d   = eop;
    data_d  = data_out;
    if (start || advance) begin
      valid_d = 1'b1;
      sop_d   = first;
      eop_d   = last;
      data_d  = frame_sel[idx*DATA_WIDTH +: DATA_WIDTH];
    end else if (eop_done) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      data_d  = '0;
    end
  end

  // State, frame and registered stream outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      frame_q  <= '0;
      valid    <= 1'b0;
      sop      <= 1'b0;
      eop      <= 1'b0;
      data_out <= '0;
      len_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      valid    <= valid_d;
      sop      <= sop_d;
      eop      <= eop_d;
      data_out <= data_d;
      len_err  <= take && !len_ok;
      if (start) frame_q <= data_in;
    end
  end

`ifdef STREAM_SRC_PKT_CNT_EN
  // Packet counter wraps; error counter saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (eop_done) pkt_cnt <= pkt_cnt + 16'd1;
      if (len_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
